// File: rtl/acoustics_pkg.sv
// Shared constants and FSM encoding for the ADC ping-pong sample writer.
// Parameter defaults, derived field widths and the writer state type.
package acoustics_pkg;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_PAGE_SAMPLES = 1024;
  localparam int DEF_ADDR_W       = 16;

  // Channel and set-index field widths inside the SRAM address
  localparam int CH_W  = $clog2(DEF_NUM_CH);
  localparam int IDX_W = $clog2(DEF_PAGE_SAMPLES);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/pingpong_addr_gen.sv
// Channel / set-index / fill-bank counters for the ping-pong writer.
// Counters point at the next write; mem_addr, wrap and page_done describe the write on the bus.
module pingpong_addr_gen
  import acoustics_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int PAGE_SAMPLES = DEF_PAGE_SAMPLES,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              BF_I_clk,
  input  logic              srst,
  input  logic              issue,
  input  logic              flip,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              wrap,
  output logic              page_done,
  output logic              fill_bank
);

  localparam int CH_BITS  = $clog2(NUM_CH);
  localparam int IDX_BITS = $clog2(PAGE_SAMPLES);

  logic [CH_BITS-1:0]  ch_reg;
  logic [IDX_BITS-1:0] set_idx_reg;
  logic                fill_bank_reg;
  logic                ch_last;
  logic                idx_last;
  logic [ADDR_W-1:0]   addr_next;

  assign ch_last   = (ch_reg == CH_BITS'(NUM_CH - 1));
  assign idx_last  = (set_idx_reg == IDX_BITS'(PAGE_SAMPLES - 1));
  assign addr_next = ADDR_W'({fill_bank_reg, set_idx_reg, ch_reg});
  assign fill_bank = fill_bank_reg;

  always_ff @(posedge BF_I_clk) begin
    if (srst) begin
      ch_reg        <= '0;
      set_idx_reg   <= '0;
      fill_bank_reg <= 1'b1;
      mem_addr      <= '0;
      wrap          <= 1'b0;
      page_done     <= 1'b0;
    end else begin
      if (issue) begin
        mem_addr  <= addr_next;
        ch_reg    <= ch_reg + 1'b1;
        wrap      <= ch_last;
        page_done <= ch_last && idx_last;
        // set_idx is a power-of-two counter, so the page wrap to 0 is free
        if (ch_last) begin
          set_idx_reg <= set_idx_reg + 1'b1;
        end
      end else begin
        wrap      <= 1'b0;
        page_done <= 1'b0;
      end
      if (flip) begin
        fill_bank_reg <= ~fill_bank_reg;
      end
    end
  end

endmodule

// File: rtl/adc_pingpong_writer.sv
// Captures one ADC sample set per adc_valid and writes it channel-interleaved into a
// two-bank sample SRAM, handing full pages to the map controller via sample_rdy/bank_select.
module adc_pingpong_writer
  import acoustics_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PAGE_SAMPLES = DEF_PAGE_SAMPLES,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                     BF_I_clk,
  input  logic                     I_rst,
  input  logic                     soft_reset,
  input  logic                     adc_valid,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic                     read_ack,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     bank_select,
  output logic                     sample_rdy,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     overrun,
  output logic                     sample_drop
);

  logic srst;
  assign srst = I_rst | soft_reset;

  state_t state_reg, state_next;
  logic   accept, issue, drop;
  logic   wrap, page_done, fill_bank;
  logic   rdy_after_ack, flip, overrun_set, sample_rdy_next;

  logic [NUM_CH*DATA_W-1:0] shift_reg;

  pingpong_addr_gen #(
    .NUM_CH      (NUM_CH),
    .PAGE_SAMPLES(PAGE_SAMPLES),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .BF_I_clk (BF_I_clk),
    .srst     (srst),
    .issue    (issue),
    .flip     (flip),
    .mem_addr (mem_addr),
    .wrap     (wrap),
    .page_done(page_done),
    .fill_bank(fill_bank)
  );

  always_ff @(posedge BF_I_clk) begin
    if (srst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    issue      = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (adc_valid) begin
          accept     = 1'b1;
          issue      = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // A set arriving while busy, including on the final write cycle, is discarded
        drop = adc_valid;
        if (wrap) begin
          state_next = IDLE;
        end else begin
          issue = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The ack is applied before page completion is judged, so a same-cycle ack still lets the bank flip
  always_comb begin
    rdy_after_ack   = sample_rdy & ~read_ack;
    flip            = page_done & ~rdy_after_ack;
    overrun_set     = page_done & rdy_after_ack;
    sample_rdy_next = page_done | rdy_after_ack;
  end

  always_ff @(posedge BF_I_clk) begin
    if (srst) begin
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      shift_reg   <= '0;
      bank_select <= 1'b0;
      sample_rdy  <= 1'b0;
      cur_addr    <= '0;
      overrun     <= 1'b0;
      sample_drop <= 1'b0;
    end else begin
      mem_we <= issue;
      if (accept) begin
        mem_wdata <= adc_data[DATA_W-1:0];
        shift_reg <= adc_data >> DATA_W;
      end else if (issue) begin
        mem_wdata <= shift_reg[DATA_W-1:0];
        shift_reg <= shift_reg >> DATA_W;
      end
      if (mem_we) begin
        cur_addr <= mem_addr;
      end
      sample_rdy <= sample_rdy_next;
      if (flip) begin
        bank_select <= fill_bank;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end
      if (drop) begin
        sample_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_pingpong_writer.sv
// Directed plus randomized bench for adc_pingpong_writer against a schedule-based
// reference model (expected write list, page events, handshake flags).
module tb_adc_pingpong_writer;
  import acoustics_pkg::*;

  localparam int NC   = DEF_NUM_CH;
  localparam int DW   = DEF_DATA_W;
  localparam int PS   = DEF_PAGE_SAMPLES;
  localparam int AW   = DEF_ADDR_W;
  localparam int BANK = 1 << (IDX_W + CH_W);

  logic               BF_I_clk = 1'b0;
  logic               I_rst = 1'b1;
  logic               soft_reset = 1'b0;
  logic               adc_valid = 1'b0;
  logic [NC*DW-1:0]   adc_data = '0;
  logic               read_ack = 1'b0;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               bank_select;
  logic               sample_rdy;
  logic [AW-1:0]      cur_addr;
  logic               overrun;
  logic               sample_drop;

  adc_pingpong_writer dut (
    .BF_I_clk   (BF_I_clk),
    .I_rst      (I_rst),
    .soft_reset (soft_reset),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .read_ack   (read_ack),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .bank_select(bank_select),
    .sample_rdy (sample_rdy),
    .cur_addr   (cur_addr),
    .overrun    (overrun),
    .sample_drop(sample_drop)
  );

  always #5 BF_I_clk = ~BF_I_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each accepted set becomes NUM_CH scheduled writes
  typedef struct {
    int          edge_no;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t wq[$];

  int          edge_n = 0;
  int          m_fill = 1, m_idx = 0, m_sel = 0, m_rdy = 0, m_ovr = 0, m_drop = 0;
  int          m_busy_until = -100, m_page_at = -1;
  int          m_we = 0;
  logic [15:0] m_mem_addr = '0, m_wdata = '0, m_cur_addr = '0;
  int          we_count = 0;
  logic [15:0] first_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    int rdy_eff;
    if (I_rst || soft_reset) begin
      m_fill = 1; m_idx = 0; m_sel = 0; m_rdy = 0; m_ovr = 0; m_drop = 0;
      m_busy_until = -100; m_page_at = -1; m_we = 0;
      m_mem_addr = '0; m_wdata = '0; m_cur_addr = '0;
      wq.delete();
    end else begin
      if (m_we != 0) m_cur_addr = m_mem_addr;
      rdy_eff = (m_rdy != 0 && !read_ack) ? 1 : 0;
      if (m_page_at == edge_n) begin
        if (rdy_eff == 0) begin
          m_sel = m_fill; m_fill = 1 - m_fill;
        end else begin
          m_ovr = 1;
        end
        m_rdy = 1;
      end else begin
        m_rdy = rdy_eff;
      end
      if (adc_valid) begin
        if (edge_n > m_busy_until) begin
          for (int c = 0; c < NC; c++) begin
            wr_t w;
            w.edge_no = edge_n + c;
            w.addr    = 16'(m_fill * BANK + m_idx * NC + c);
            w.data    = adc_data[c*DW +: DW];
            wq.push_back(w);
          end
          if (m_idx == PS - 1) m_page_at = edge_n + NC;
          m_idx = (m_idx + 1) % PS;
          m_busy_until = edge_n + NC;
        end else begin
          m_drop = 1;
        end
      end
      m_we = 0;
      if (wq.size() > 0 && wq[0].edge_no == edge_n) begin
        m_we = 1;
        m_mem_addr = wq[0].addr;
        m_wdata = wq[0].data;
        void'(wq.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge BF_I_clk);
    #1;
    edge_n++;
    model_edge();
    if (mem_we === 1'b1) we_count++;
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("bank_select", 32'(bank_select), 32'(m_sel));
    chk("sample_rdy", 32'(sample_rdy), 32'(m_rdy));
    chk("cur_addr", 32'(cur_addr), 32'(m_cur_addr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("sample_drop", 32'(sample_drop), 32'(m_drop));
  endtask

  // One set: valid for one edge, run its writes, optional ack on the page-done cycle, then idle
  task automatic send_set(input logic [NC*DW-1:0] d, input int extra, input bit ack_done);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    first_addr = mem_addr;
    for (int i = 0; i < NC - 1; i++) tick();
    read_ack = ack_done;
    tick();
    read_ack = 1'b0;
    for (int i = 0; i < extra; i++) tick();
  endtask

  function automatic logic [NC*DW-1:0] rand_set();
    return {$urandom(), $urandom()};
  endfunction

  task automatic fill_sets(input int n, input bit ack_last);
    for (int s = 0; s < n; s++) send_set(rand_set(), $urandom_range(0, 2), ack_last && (s == n - 1));
  endtask

  initial begin
    logic [NC*DW-1:0] d;

    // 1: reset
    I_rst = 1'b1;
    repeat (3) tick();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_bank_select", 32'(bank_select), 32'd0);
    chk("rst_sample_rdy", 32'(sample_rdy), 32'd0);
    chk("rst_cur_addr", 32'(cur_addr), 32'd0);
    I_rst = 1'b0;
    we_count = 0;
    repeat (5) tick();
    chk("idle_no_writes", 32'(we_count), 32'd0);
    $display("step reset: checks=%0d errors=%0d", checks, errors);

    // 2: single set
    d = 64'h4444_3333_2222_1111;
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (c > 0) tick();
      chk("single_we", 32'(mem_we), 32'd1);
      chk("single_addr", 32'(mem_addr), 32'h1000 + 32'(c));
      chk("single_data", 32'(mem_wdata), 32'(d[c*DW +: DW]));
    end
    tick();
    chk("single_we_end", 32'(mem_we), 32'd0);
    chk("single_cur_addr", 32'(cur_addr), 32'h1003);
    tick();
    $display("step single set: checks=%0d errors=%0d", checks, errors);

    // 3: first page completes -> flip
    fill_sets(PS - 1, 1'b0);
    chk("flip_bank_select", 32'(bank_select), 32'd1);
    chk("flip_sample_rdy", 32'(sample_rdy), 32'd1);
    send_set(rand_set(), 1, 1'b0);
    chk("flip_next_addr", 32'(first_addr), 32'h0000);
    $display("step page flip: checks=%0d errors=%0d", checks, errors);

    // 4: second page with no ack -> overrun, bank kept, third page restarts at 0
    fill_sets(PS - 1, 1'b0);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    chk("ovr_bank_select", 32'(bank_select), 32'd1);
    send_set(rand_set(), 1, 1'b0);
    chk("ovr_third_addr", 32'(first_addr), 32'h0000);
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
    chk("ack_clears_rdy", 32'(sample_rdy), 32'd0);
    $display("step overrun: checks=%0d errors=%0d", checks, errors);

    // 5: drop on valid two cycles after an accepted one, then soft reset
    tick();
    we_count = 0;
    adc_data = rand_set(); adc_valid = 1'b1; tick();
    adc_valid = 1'b0; tick();
    adc_data = rand_set(); adc_valid = 1'b1; tick();
    adc_valid = 1'b0;
    repeat (4) tick();
    chk("drop_write_count", 32'(we_count), 32'd4);
    chk("drop_flag", 32'(sample_drop), 32'd1);
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    chk("srst_drop", 32'(sample_drop), 32'd0);
    chk("srst_overrun", 32'(overrun), 32'd0);
    chk("srst_bank_select", 32'(bank_select), 32'd0);
    $display("step drop/soft reset: checks=%0d errors=%0d", checks, errors);

    // 4b: ack on the page-done cycle of a second page -> flip, no overrun
    fill_sets(PS, 1'b0);
    fill_sets(PS, 1'b1);
    chk("ackdone_overrun", 32'(overrun), 32'd0);
    chk("ackdone_bank_select", 32'(bank_select), 32'd0);
    chk("ackdone_sample_rdy", 32'(sample_rdy), 32'd1);
    $display("step ack on page done: checks=%0d errors=%0d", checks, errors);

    // 6: reset during the second write cycle
    adc_data = rand_set(); adc_valid = 1'b1; tick();
    adc_valid = 1'b0; tick();
    I_rst = 1'b1; tick(); I_rst = 1'b0;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    send_set(rand_set(), 1, 1'b0);
    chk("midrst_next_addr", 32'(first_addr), 32'h1000);
    $display("step reset mid-write: checks=%0d errors=%0d", checks, errors);

    // Random traffic: valids, acks and occasional soft resets
    for (int i = 0; i < 600; i++) begin
      adc_data   = rand_set();
      adc_valid  = ($urandom_range(0, 3) == 0);
      read_ack   = ($urandom_range(0, 9) == 0);
      soft_reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    adc_valid = 1'b0; read_ack = 1'b0; soft_reset = 1'b0;
    repeat (6) tick();
    $display("step random traffic: checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
